mem_stage: RTL and testbench

//  Memory-access pipeline stage. Sits between EX and wb_stage.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_if.sv | 62 ++++++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared definitions for the MEM pipeline stage. Holds the funct3
//             access-width codes, the bubble instruction word, the FSM state
//             encoding and the alignment helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

  // Instruction word that marks a bubble on the MEM/WB boundary (addi x0,x0,0)
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // funct3 load/store width and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width, taken from funct3[1:0]; any other code is handled as a word
  localparam logic [1:0] WID_BYTE = 2'b00;
  localparam logic [1:0] WID_HALF = 2'b01;

  // Access FSM: idle/issue, or waiting for dmem_ack
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // An access is misaligned when a halfword sits on an odd byte or a word is
  // not on a 4-byte boundary. Bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] lane);
    logic mis;
    case (width)
      WID_BYTE: mis = 1'b0;
      WID_HALF: mis = lane[0];
      default:  mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Purpose  : Bundle of the EX-side request, data-memory handshake and MEM/WB
//             result signals around the MEM stage. The master modport is the
//             stage's own view; slave is the view of its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_if;

  // EX -> MEM
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic        ex_mmr_we;
  logic        stall_out;

  // Data memory handshake
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  // MEM -> WB
  logic [31:0] rd_data_from_mem;
  logic [4:0]  rd_addr_from_mem;
  logic        we_to_wb;
  logic [31:0] inst_from_MEM;
  logic [31:0] loadnoc_data;
  logic [31:0] mmr_location;
  logic        mmr_we_wb;
  logic        mem_err;

  modport master (
    input  ex_valid, ex_inst, ex_alu_result, ex_store_data, ex_rd_addr,
           ex_we, ex_mem_rd, ex_mem_wr, ex_funct3, ex_mmr_we,
           dmem_ack, dmem_rdata,
    output stall_out, dmem_req, dmem_wr, dmem_addr, dmem_wdata, dmem_be,
           rd_data_from_mem, rd_addr_from_mem, we_to_wb, inst_from_MEM,
           loadnoc_data, mmr_location, mmr_we_wb, mem_err
  );

  modport slave (
    output ex_valid, ex_inst, ex_alu_result, ex_store_data, ex_rd_addr,
           ex_we, ex_mem_rd, ex_mem_wr, ex_funct3, ex_mmr_we,
           dmem_ack, dmem_rdata,
    input  stall_out, dmem_req, dmem_wr, dmem_addr, dmem_wdata, dmem_be,
           rd_data_from_mem, rd_addr_from_mem, we_to_wb, inst_from_MEM,
           loadnoc_data, mmr_location, mmr_we_wb, mem_err
  );

endinterface : mem_stage_if
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_load_align
//  Purpose  : Combinational load aligner. Selects the addressed byte/halfword
//             lane of the raw read word and sign- or zero-extends it.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by width/sign extension
  always_comb begin
    case (lane_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    // Aligned halfwords only ever start at byte 0 or byte 2
    w_half = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
      F3_H:    data_o = {{16{w_half[15]}}, w_half};
      F3_BU:   data_o = {24'd0, w_byte};
      F3_HU:   data_o = {16'd0, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule : mem_stage_load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access pipeline stage between EX and WB. Issues loads and
//             stores over a req/ack handshake, aligns load data, forwards the
//             loadnoc/MMR fields and registers results into MEM/WB. Stalls EX
//             while an access is outstanding and aborts on timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.master bus
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC);

  state_e      state_q;
  logic [7:0]  cnt_q;

  // Copy of the request taken while idle; drives the bus during WAIT
  logic [31:0] cap_addr_q;
  logic [31:0] cap_sdata_q;
  logic [31:0] cap_inst_q;
  logic [2:0]  cap_f3_q;
  logic [4:0]  cap_rd_q;
  logic        cap_we_q;
  logic        cap_wr_q;

  // MEM/WB boundary registers
  logic [31:0] rd_data_q;
  logic [4:0]  rd_addr_q;
  logic        we_q;
  logic [31:0] inst_q;
  logic [31:0] loadnoc_q;
  logic [31:0] mmr_loc_q;
  logic        mmr_we_q;
  logic        err_q;

  logic        w_in_wait;
  logic [31:0] w_addr;
  logic [31:0] w_sdata;
  logic [31:0] w_inst;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic        w_we;
  logic        w_wr;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_req;
  logic        w_retire_mem;
  logic        w_retire_direct;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // Pick the live EX fields while idle, the captured copy while waiting
  always_comb begin
    w_in_wait = (state_q == ST_WAIT);
    if (w_in_wait) begin
      w_addr  = cap_addr_q;
      w_sdata = cap_sdata_q;
      w_inst  = cap_inst_q;
      w_f3    = cap_f3_q;
      w_rd    = cap_rd_q;
      w_we    = cap_we_q;
      w_wr    = cap_wr_q;
    end else begin
      w_addr  = bus.ex_alu_result;
      w_sdata = bus.ex_store_data;
      w_inst  = bus.ex_inst;
      w_f3    = bus.ex_funct3;
      w_rd    = bus.ex_rd_addr;
      w_we    = bus.ex_we;
      // A slot flagged as both load and store is executed as a store
      w_wr    = bus.ex_mem_wr;
    end

    // MMR (loadnoc) ops never touch data memory
    w_is_mem   = bus.ex_valid & ~bus.ex_mmr_we & (bus.ex_mem_rd | bus.ex_mem_wr);
    w_misalign = is_misaligned(bus.ex_funct3[1:0], bus.ex_alu_result[1:0]);
    w_timeout  = w_in_wait & (cnt_q == TIMEOUT_LIMIT);
    // Gated by reset so an access in flight vanishes the moment reset asserts
    w_req      = reset & (w_in_wait ? ~w_timeout : (w_is_mem & ~w_misalign));

    w_retire_mem    = w_req & bus.dmem_ack;
    w_retire_direct = ~w_in_wait & bus.ex_valid &
                      (bus.ex_mmr_we | ~(bus.ex_mem_rd | bus.ex_mem_wr));
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    case (w_f3[1:0])
      WID_BYTE: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{w_sdata[7:0]}};
      end
      WID_HALF: begin
        w_be    = 4'b0011 << w_addr[1:0];
        w_wdata = {2{w_sdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_sdata;
      end
    endcase
  end

  mem_stage_load_align u_load_align (
    .rdata_i  (bus.dmem_rdata),
    .lane_i   (w_addr[1:0]),
    .funct3_i (w_f3),
    .data_o   (w_load_data)
  );

  // Data-memory request and upstream stall; stall releases in the ack cycle
  always_comb begin
    bus.dmem_req   = w_req;
    bus.dmem_wr    = w_req & w_wr;
    bus.dmem_addr  = w_req ? {w_addr[31:2], 2'b00} : 32'd0;
    bus.dmem_be    = w_req ? w_be : 4'd0;
    bus.dmem_wdata = (w_req & w_wr) ? w_wdata : 32'd0;
    bus.stall_out  = w_req & ~bus.dmem_ack;
  end

  // Capture the request while idle so it stays stable across WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_addr_q  <= '0;
      cap_sdata_q <= '0;
      cap_inst_q  <= '0;
      cap_f3_q    <= '0;
      cap_rd_q    <= '0;
      cap_we_q    <= 1'b0;
      cap_wr_q    <= 1'b0;
    end else if (!w_in_wait) begin
      cap_addr_q  <= bus.ex_alu_result;
      cap_sdata_q <= bus.ex_store_data;
      cap_inst_q  <= bus.ex_inst;
      cap_f3_q    <= bus.ex_funct3;
      cap_rd_q    <= bus.ex_rd_addr;
      cap_we_q    <= bus.ex_we;
      cap_wr_q    <= bus.ex_mem_wr;
    end
  end

  // Access FSM, timeout counter and registered MEM/WB outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
      inst_q    <= NOP_INST;
      loadnoc_q <= '0;
      mmr_loc_q <= '0;
      mmr_we_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Bubble unless something retires this cycle
      rd_data_q <= '0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
      inst_q    <= NOP_INST;
      loadnoc_q <= '0;
      mmr_loc_q <= '0;
      mmr_we_q  <= 1'b0;
      err_q     <= (~w_in_wait & w_is_mem & w_misalign) | w_timeout;

      if (w_retire_direct | w_retire_mem) begin
        rd_addr_q <= w_rd;
        inst_q    <= w_inst;
        loadnoc_q <= w_sdata;
        mmr_loc_q <= w_addr;
        rd_data_q <= (w_retire_mem & ~w_wr) ? w_load_data : w_addr;
        we_q      <= w_we & ~(w_retire_mem & w_wr);
        mmr_we_q  <= w_retire_direct & bus.ex_mmr_we;
      end

      case (state_q)
        ST_IDLE: begin
          // The issue cycle already counts as the first cycle of waiting
          if (w_req & ~bus.dmem_ack) begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'd1;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_timeout | bus.dmem_ack) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // MEM/WB outputs come straight from the boundary registers
  always_comb begin
    bus.rd_data_from_mem = rd_data_q;
    bus.rd_addr_from_mem = rd_addr_q;
    bus.we_to_wb         = we_q;
    bus.inst_from_MEM    = inst_q;
    bus.loadnoc_data     = loadnoc_q;
    bus.mmr_location     = mmr_loc_q;
    bus.mmr_we_wb        = mmr_we_q;
    bus.mem_err          = err_q;
  end

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. Directed cases plus random
//             operations compared against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  localparam int          TO  = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_MMR = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;

  mem_stage_if bus ();

  mem_stage #(.NOP_INST(NOP), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
    int lane = int'(a % 4);
    case (f3)
      3'd1, 3'd5: return (lane % 2) != 0;
      3'd2:       return lane != 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint unsigned w    = rd;
    int              lane = int'(a % 4);
    longint          v;
    logic [63:0]     r;
    case (f3)
      3'd0: begin v = longint'((w >> (8 * lane)) % 256);   if (v >= 128)   v -= 256;   end
      3'd1: begin v = longint'((w >> (8 * lane)) % 65536); if (v >= 32768) v -= 65536; end
      3'd4: v = longint'((w >> (8 * lane)) % 256);
      3'd5: v = longint'((w >> (8 * lane)) % 65536);
      default: v = longint'(w);
    endcase
    r = 64'(v);
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int lane = int'(a % 4);
    int be;
    logic [31:0] r;
    case (f3)
      3'd0:    be = 1 << lane;
      3'd1:    be = 3 << lane;
      default: be = 15;
    endcase
    r = 32'(be);
    return r;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    longint unsigned v = d;
    logic [63:0] r;
    case (f3)
      3'd0:    r = (v % 256) * 64'h0101_0101;
      3'd1:    r = (v % 65536) * 64'h0001_0001;
      default: r = v;
    endcase
    return r[31:0];
  endfunction

  task automatic set_idle();
    bus.ex_valid      = 1'b0;
    bus.ex_inst       = 32'd0;
    bus.ex_alu_result = 32'd0;
    bus.ex_store_data = 32'd0;
    bus.ex_rd_addr    = 5'd0;
    bus.ex_we         = 1'b0;
    bus.ex_mem_rd     = 1'b0;
    bus.ex_mem_wr     = 1'b0;
    bus.ex_funct3     = 3'd0;
    bus.ex_mmr_we     = 1'b0;
    bus.dmem_ack      = 1'b0;
    bus.dmem_rdata    = 32'd0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_we"},    bus.we_to_wb, 1'b0);
    chk({tag, "_mmrwe"}, bus.mmr_we_wb, 1'b0);
    chk({tag, "_inst"},  bus.inst_from_MEM, NOP);
  endtask

  // One instruction in EX; ack arrives 'delay' cycles after the issue cycle
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int delay, input logic [4:0] rd, input logic we,
                       input logic both, output int stalls);
    logic [31:0] inst   = $urandom;
    bit          is_mem = (kind == K_LD) || (kind == K_ST);
    bit          mis    = is_mem && ref_mis(f3, addr);
    bit          done   = 1'b0;
    stalls = 0;
    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_inst       = inst;
    bus.ex_alu_result = addr;
    bus.ex_store_data = sdata;
    bus.ex_rd_addr    = rd;
    bus.ex_we         = we;
    bus.ex_mem_rd     = (kind == K_LD) || (kind == K_ST && both);
    bus.ex_mem_wr     = (kind == K_ST);
    bus.ex_funct3     = f3;
    bus.ex_mmr_we     = (kind == K_MMR);
    bus.dmem_rdata    = rdata;
    for (int k = 0; k <= TO + 1 && !done; k++) begin
      bit exp_req = is_mem && !mis && (k < TO);
      bit ack     = exp_req && (k == delay);
      bit err;
      bus.dmem_ack = ack;
      #2;
      chk("req", bus.dmem_req, exp_req);
      chk("stall", bus.stall_out, exp_req && !ack);
      if (bus.stall_out) stalls++;
      if (exp_req) begin
        chk("addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
        chk("wr", bus.dmem_wr, kind == K_ST);
        if (kind == K_ST) begin
          chk("be", bus.dmem_be, ref_be(f3, addr));
          chk("wdata", bus.dmem_wdata, ref_wdata(f3, sdata));
        end
      end
      done = !is_mem || mis || ack || (k == TO);
      err  = is_mem && (mis || (k == TO));
      @(posedge clk);
      #1;
      chk("err", bus.mem_err, err);
      if (done && !err) begin
        chk("rd_data", bus.rd_data_from_mem, (kind == K_LD) ? ref_load(f3, addr, rdata) : addr);
        chk("rd_addr", bus.rd_addr_from_mem, rd);
        chk("we", bus.we_to_wb, (kind == K_ST) ? 1'b0 : we);
        chk("inst", bus.inst_from_MEM, inst);
        chk("mmr_we", bus.mmr_we_wb, kind == K_MMR);
        chk("mmr_loc", bus.mmr_location, addr);
        chk("loadnoc", bus.loadnoc_data, sdata);
      end else begin
        chk_bubble("wait");
      end
      if (!done) @(negedge clk);
    end
    // Idle slot afterwards: bubble, and mem_err must have been a single pulse
    @(negedge clk);
    set_idle();
    @(posedge clk);
    #1;
    chk_bubble("idle");
    chk("err_pulse", bus.mem_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [2:0]  ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    set_idle();
    #2 reset = 1'b0;
    #1;
    chk("rst_req", bus.dmem_req, 1'b0);
    chk("rst_stall", bus.stall_out, 1'b0);
    chk("rst_rdata", bus.rd_data_from_mem, 32'd0);
    chk("rst_rdaddr", bus.rd_addr_from_mem, 5'd0);
    chk("rst_we", bus.we_to_wb, 1'b0);
    chk("rst_inst", bus.inst_from_MEM, NOP);
    chk("rst_loadnoc", bus.loadnoc_data, 32'd0);
    chk("rst_mmrloc", bus.mmr_location, 32'd0);
    chk("rst_mmrwe", bus.mmr_we_wb, 1'b0);
    chk("rst_err", bus.mem_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // LW, ack in the issue cycle: no stall
    do_op(K_LD, 3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 5'd3, 1'b1, 1'b0, st);
    chk("lw_stalls", st, 0);
    // LB from lane 3 with 0x80, ack three cycles late: three stall cycles
    do_op(K_LD, 3'd0, 32'h103, 32'd0, 32'h8012_3456, 3, 5'd4, 1'b1, 1'b0, st);
    chk("lb_stalls", st, 3);
    // SH to upper half
    do_op(K_ST, 3'd1, 32'h102, 32'h0000_1234, 32'd0, 1, 5'd0, 1'b0, 1'b0, st);
    // Misaligned LW and SH
    do_op(K_LD, 3'd2, 32'h101, 32'd0, 32'd0, 0, 5'd5, 1'b1, 1'b0, st);
    chk("mis_stalls", st, 0);
    do_op(K_ST, 3'd1, 32'h201, 32'h55, 32'd0, 0, 5'd0, 1'b0, 1'b1, st);
    // MMR op
    do_op(K_MMR, 3'd0, 32'h4000_0010, 32'h0000_00A5, 32'd0, 0, 5'd7, 1'b0, 1'b0, st);
    // Load and store both flagged: behaves as a store
    do_op(K_ST, 3'd2, 32'h300, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2, 5'd9, 1'b1, 1'b1, st);
    // No ack at all: timeout after TO request cycles
    do_op(K_LD, 3'd2, 32'h400, 32'd0, 32'd0, 1000, 5'd6, 1'b1, 1'b0, st);
    chk("to_stalls", st, TO);

    // Reset while waiting drops the request at once
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_mem_rd = 1'b1; bus.ex_funct3 = 3'd2;
    bus.ex_alu_result = 32'h500; bus.ex_we = 1'b1; bus.ex_rd_addr = 5'd8;
    repeat (3) @(negedge clk);
    #2;
    chk("prerst_req", bus.dmem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_req", bus.dmem_req, 1'b0);
    chk("midrst_stall", bus.stall_out, 1'b0);
    chk_bubble("midrst");
    set_idle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_bubble("postrst");
    chk("postrst_req", bus.dmem_req, 1'b0);

    // Random operations
    for (int i = 0; i < 150; i++) begin
      int          kind  = int'($urandom_range(0, 3));
      logic [2:0]  f3    = (kind == K_ST) ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      logic [31:0] addr  = $urandom;
      int          delay = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, TO - 1));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_op(kind, f3, addr, $urandom, $urandom, delay, 5'($urandom),
            1'($urandom), 1'($urandom), st);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule : tb_mem_stage
`default_nettype wire
